// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU request scheduler: FSM encoding, request/result bundles.
// Latency: n/a (types only). Backpressure: n/a.
// Included by rr_arbiter2 and alu_arbiter.
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int OPC_W  = 6;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
        logic              vin;
    } alu_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] dout;
        logic              cout;
        logic              vout;
        logic              qnz;
    } alu_rsp_t;

    function automatic alu_req_t pick_req(input logic sel, input alu_req_t r0, input alu_req_t r1);
        return sel ? r1 : r0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin arbiter holding only the last-granted pointer.
// Latency: grant is combinational from valid and the pointer; pointer moves on accept.
// Backpressure: the caller qualifies grant with its own ready; no grant is held.
module rr_arbiter2
    import alu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // Set means port 1 won last, so port 0 is favoured on the next contest.
    logic last_grant;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; ALU_MCP_EN adds a multi-cycle WAIT hold.
// Latency: response pulse 2 cycles after accept, 2+MCP_CYCLES for multi-cycle ops when ALU_MCP_EN is defined.
// Backpressure: readies are raised only in IDLE; a waiting requester holds its payload until then.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int MCP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,
    input  logic        req0_vin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,
    input  logic        req1_vin,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_dout,
    output logic        rsp_cout,
    output logic        rsp_vout,
    output logic        rsp_qnz,
    output logic        busy,
    output logic [31:0] alu_din_a,
    output logic [31:0] alu_din_b,
    output logic [5:0]  alu_opcode,
    output logic        alu_cin,
    output logic        alu_vin,
    input  logic [31:0] alu_dout,
    input  logic        alu_cout,
    input  logic        alu_vout,
    input  logic        alu_qnzout,
    input  logic        alu_mcp
);

    arb_state_t state_q, state_d;
    logic [1:0] grant;
    logic       in_idle;
    logic       accept;
    logic       capture;
    logic       owner_q;
    logic [1:0] rsp_vld_q;
    alu_req_t   req0, req1, win, alu_q;
    alu_rsp_t   alu_res, rsp_q;

    assign req0    = {req0_opcode, req0_a, req0_b, req0_cin, req0_vin};
    assign req1    = {req1_opcode, req1_a, req1_b, req1_cin, req1_vin};
    assign alu_res = {alu_dout, alu_cout, alu_vout, alu_qnzout};

    assign in_idle    = (state_q == ARB_IDLE);
    assign req0_ready = in_idle & grant[0] & ~rst;
    assign req1_ready = in_idle & grant[1] & ~rst;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign win        = pick_req(grant[1], req0, req1);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

`ifdef ALU_MCP_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // Without the multi-cycle option the ALU's hold request has no meaning here.
    logic unused_mcp;
    assign unused_mcp = alu_mcp & (MCP_CYCLES > 0);
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
`ifdef ALU_MCP_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    state_d = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
`ifdef ALU_MCP_EN
                if (alu_mcp) begin
                    state_d = ARB_WAIT;
                    cnt_d   = CNT_W'(MCP_CYCLES);
                end else begin
                    capture = 1'b1;
                    state_d = ARB_IDLE;
                end
`else
                capture = 1'b1;
                state_d = ARB_IDLE;
`endif
            end
`ifdef ALU_MCP_EN
            ARB_WAIT: begin
                // Operands stay parked on the ALU; the last hold cycle doubles as the capture cycle.
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ALU_MCP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q     <= '0;
            owner_q   <= 1'b0;
            rsp_q     <= '0;
            rsp_vld_q <= 2'b00;
        end else begin
            rsp_vld_q <= 2'b00;
            if (accept) begin
                alu_q   <= win;
                owner_q <= grant[1];
            end
            if (capture) begin
                rsp_q     <= alu_res;
                rsp_vld_q <= owner_q ? 2'b10 : 2'b01;
            end
        end
    end

    assign busy       = ~in_idle;
    assign alu_opcode = alu_q.opcode;
    assign alu_din_a  = alu_q.a;
    assign alu_din_b  = alu_q.b;
    assign alu_cin    = alu_q.cin;
    assign alu_vin    = alu_q.vin;
    assign rsp_dout   = rsp_q.dout;
    assign rsp_cout   = rsp_q.cout;
    assign rsp_vout   = rsp_q.vout;
    assign rsp_qnz    = rsp_q.qnz;
    assign rsp0_valid = rsp_vld_q[0];
    assign rsp1_valid = rsp_vld_q[1];

    a_rsp_onehot: assert property (@(posedge clk) disable iff (rst) !(rsp0_valid && rsp1_valid));

`ifdef ALU_MCP_EN
    a_wait_hold: assert property (@(posedge clk) disable iff (rst) (state_q == ARB_WAIT) |-> $stable(alu_q));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stands in for the ALU, drives directed then random requests,
// and checks every cycle against a cycle-count/queue model of the scheduler.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int MCP = 2;
`ifdef ALU_MCP_EN
    localparam bit MCP_EN = 1'b1;
`else
    localparam bit MCP_EN = 1'b0;
`endif
    localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02,
                           OP_OR  = 6'h03, OP_XOR = 6'h04, OP_MUL = 6'h10;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        vin;
    } req_t;

    typedef struct packed {
        logic [31:0] dout;
        logic        cout;
        logic        vout;
        logic        qnz;
    } res_t;

    typedef struct {
        int   due;
        int   port;
        res_t res;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [5:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_cin, req0_vin, req1_cin, req1_vin;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_dout;
    logic        rsp_cout, rsp_vout, rsp_qnz, busy;
    logic [31:0] alu_din_a, alu_din_b, alu_dout;
    logic [5:0]  alu_opcode;
    logic        alu_cin, alu_vin, alu_cout, alu_vout, alu_qnzout, alu_mcp;
    res_t        alu_r;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.MCP_CYCLES(MCP)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_vin(req0_vin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_vin(req1_vin),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_dout(rsp_dout),
        .rsp_cout(rsp_cout), .rsp_vout(rsp_vout), .rsp_qnz(rsp_qnz), .busy(busy),
        .alu_din_a(alu_din_a), .alu_din_b(alu_din_b), .alu_opcode(alu_opcode),
        .alu_cin(alu_cin), .alu_vin(alu_vin), .alu_dout(alu_dout), .alu_cout(alu_cout),
        .alu_vout(alu_vout), .alu_qnzout(alu_qnzout), .alu_mcp(alu_mcp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic vin);
        res_t r;
        logic [32:0] s;
        r = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                r.dout = s[31:0];
                r.cout = s[32];
                r.vout = (a[31] == b[31]) && (r.dout[31] != a[31]);
            end
            OP_SUB: begin
                r.dout = a - b;
                r.cout = (a < b);
                r.vout = (a[31] != b[31]) && (r.dout[31] != a[31]);
            end
            OP_AND: begin r.dout = a & b; r.cout = cin; r.vout = vin; end
            OP_OR:  begin r.dout = a | b; r.cout = cin; r.vout = vin; end
            OP_XOR: begin r.dout = a ^ b; r.cout = cin; r.vout = vin; end
            OP_MUL: r.dout = a * b;
            default: begin r.dout = a; r.cout = cin; r.vout = vin; end
        endcase
        r.qnz = (r.dout != '0);
        return r;
    endfunction

    function automatic int op_lat(input logic [5:0] op);
        return (MCP_EN && (op == OP_MUL)) ? 2 + MCP : 2;
    endfunction

    // Stand-in ALU: combinational, asks for a multi-cycle hold on every MUL.
    always_comb alu_r = ref_alu(alu_opcode, alu_din_a, alu_din_b, alu_cin, alu_vin);
    assign alu_dout   = alu_r.dout;
    assign alu_cout   = alu_r.cout;
    assign alu_vout   = alu_r.vout;
    assign alu_qnzout = alu_r.qnz;
    assign alu_mcp    = (alu_opcode == OP_MUL);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    int   cyc = 0;
    int   free_cyc = 0;
    int   last_p = 1;
    int   g;
    exp_t pend[$];
    req_t held;
    res_t rsp_hold;
    req_t cur;
    bit   e_r0, e_r1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_ctrl", 64'({req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid, rsp_cout, rsp_vout, rsp_qnz, rsp_dout}), 64'd0);
            chk("rst_alu", 64'({alu_opcode, alu_cin, alu_vin, alu_din_a}), 64'd0);
            chk("rst_alu_b", 64'(alu_din_b), 64'd0);
            pend.delete();
            free_cyc = 0;
            last_p   = 1;
            held     = '0;
            rsp_hold = '0;
        end else begin
            g = -1;
            if (cyc >= free_cyc) begin
                if (req0_valid && req1_valid) g = (last_p == 1) ? 0 : 1;
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
            end
            chk("ready0", 64'(req0_ready), 64'(g == 0));
            chk("ready1", 64'(req1_ready), 64'(g == 1));
            chk("busy", 64'(busy), 64'(cyc < free_cyc));
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e_r0 = (pend[0].port == 0);
                e_r1 = (pend[0].port == 1);
                rsp_hold = pend[0].res;
                void'(pend.pop_front());
            end
            chk("rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'({e_r1, e_r0}));
            chk("rsp_data", 64'({rsp_dout, rsp_cout, rsp_vout, rsp_qnz}), 64'(rsp_hold));
            chk("alu_ctl_a", 64'({alu_opcode, alu_cin, alu_vin, alu_din_a}), 64'({held.op, held.cin, held.vin, held.a}));
            chk("alu_b", 64'(alu_din_b), 64'(held.b));
            if (g >= 0) begin
                cur = (g == 0) ? {req0_opcode, req0_a, req0_b, req0_cin, req0_vin}
                               : {req1_opcode, req1_a, req1_b, req1_cin, req1_vin};
                free_cyc = cyc + op_lat(cur.op);
                pend.push_back('{due: free_cyc, port: g, res: ref_alu(cur.op, cur.a, cur.b, cur.cin, cur.vin)});
                held   = cur;
                last_p = g;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int port, input req_t r, input logic v);
        if (port == 0) begin
            req0_valid = v;
            {req0_opcode, req0_a, req0_b, req0_cin, req0_vin} = r;
        end else begin
            req1_valid = v;
            {req1_opcode, req1_a, req1_b, req1_cin, req1_vin} = r;
        end
    endtask

    function automatic req_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.cin = 1'b0; r.vin = 1'b0;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        case ($urandom_range(0, 5))
            0: r.op = OP_ADD;
            1: r.op = OP_SUB;
            2: r.op = OP_AND;
            3: r.op = OP_OR;
            4: r.op = OP_XOR;
            default: r.op = OP_MUL;
        endcase
        r.a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
        r.b   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
        r.cin = 1'($urandom_range(0, 1));
        r.vin = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Drives one request until accepted, then counts cycles to its response pulse.
    task automatic do_op(input int port, input req_t r, output int lat, output res_t res, output bit other);
        bit acc;
        bit got;
        lat = 0; other = 1'b0; res = '0; acc = 1'b0; got = 1'b0;
        @(posedge clk); #1;
        drive(port, r, 1'b1);
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = (port == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        drive(port, r, 1'b0);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if ((port == 0) ? rsp1_valid : rsp0_valid) other = 1'b1;
            if ((port == 0) ? rsp0_valid : rsp1_valid) begin
                got = 1'b1;
                res = {rsp_dout, rsp_cout, rsp_vout, rsp_qnz};
            end
        end
        if (!got) lat = -1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   lat;
    res_t res;
    bit   other;
    int   order[4];
    int   n_acc;
    bit   a0, a1;
    int   waits;
    int   pulses;
    int   first_p;

    initial begin
        rst = 1'b0;
        drive(0, '0, 1'b0);
        drive(1, '0, 1'b0);
        #2 rst = 1'b1;

        // Reset: readies gated even with both requesters valid.
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_lit_ready", 64'({req0_ready, req1_ready}), 64'd0);
        chk("rst_lit_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        do_op(0, mk(OP_ADD, 32'd5, 32'd7), lat, res, other);
        chk("add_lat", 64'(lat), 64'd2);
        chk("add_res", 64'(res), 64'({32'd12, 1'b0, 1'b0, 1'b1}));
        chk("add_no_rsp1", 64'(other), 64'd0);

        do_op(1, mk(OP_ADD, 32'h7FFF_FFFF, 32'd1), lat, res, other);
        chk("ovf_dout", 64'(res.dout), 64'h8000_0000);
        chk("ovf_vout", 64'(res.vout), 64'd1);

        do_op(1, mk(OP_SUB, 32'd10, 32'd3), lat, res, other);
        chk("sub_dout", 64'(res.dout), 64'd7);

        do_op(0, mk(OP_MUL, 32'd3, 32'd4), lat, res, other);
        chk("mul_lat", 64'(lat), MCP_EN ? 64'd4 : 64'd2);
        chk("mul_dout", 64'(res.dout), 64'd12);

        // Round-robin with both ports continuously valid after reset.
        pulse_reset();
        drive(0, mk(OP_ADD, 32'd1, 32'd1), 1'b1);
        drive(1, mk(OP_ADD, 32'd2, 32'd2), 1'b1);
        n_acc = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int i = 0; i < 60 && n_acc < 4; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0) begin order[n_acc] = 0; n_acc++; end
            if (a1 && n_acc < 4) begin order[n_acc] = 1; n_acc++; end
            @(posedge clk); #1;
            if (a0) req0_a = req0_a + 32'd10;
            if (a1) req1_a = req1_a + 32'd10;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_0", 64'(order[0]), 64'd0);
        chk("rr_1", 64'(order[1]), 64'd1);
        chk("rr_2", 64'(order[2]), 64'd0);
        chk("rr_3", 64'(order[3]), 64'd1);
        repeat (4) @(posedge clk);

        // Reset while a MUL is in flight (WAIT when multi-cycle is built, EXEC otherwise).
        #1;
        drive(0, mk(OP_MUL, 32'd3, 32'd4), 1'b1);
        a0 = 1'b0;
        for (int i = 0; i < 20 && !a0; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        if (MCP_EN) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_outs", 64'({rsp0_valid, rsp1_valid, rsp_dout, alu_opcode}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, mk(OP_ADD, 32'd100, 32'd1), 1'b1);
        drive(1, mk(OP_ADD, 32'd200, 32'd2), 1'b1);
        first_p = -1; pulses = 0;
        for (int i = 0; i < 20 && first_p < 0; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) pulses++;
            if (req0_valid && req0_ready) first_p = 0;
            else if (req1_valid && req1_ready) first_p = 1;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rstw_first", 64'(first_p), 64'd0);
        chk("rstw_no_rsp", 64'(pulses), 64'd0);
        repeat (4) @(posedge clk);

        // Back-pressure: port 1 waits through port 0's op, then goes once with its payload.
        #1;
        drive(0, mk(OP_ADD, 32'd1, 32'd2), 1'b1);
        a0 = 1'b0;
        for (int i = 0; i < 20 && !a0; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive(1, mk(OP_SUB, 32'h100, 32'h1), 1'b1);
        waits = 0; a1 = 1'b0;
        for (int i = 0; i < 20 && !a1; i++) begin
            @(negedge clk);
            a1 = req1_valid && req1_ready;
            if (!a1) waits++;
        end
        chk("bp_waits", 64'(waits), 64'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        pulses = 0; res = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp1_valid) begin pulses++; res = {rsp_dout, rsp_cout, rsp_vout, rsp_qnz}; end
        end
        chk("bp_once", 64'(pulses), 64'd1);
        chk("bp_dout", 64'(res.dout), 64'hFF);

        // Random traffic with occasional drops and resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 599) == 0);
            if (!req0_valid || a0) begin
                if ($urandom_range(0, 2) != 0) drive(0, rand_req(), 1'b1);
                else req0_valid = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid || a1) begin
                if ($urandom_range(0, 2) != 0) drive(1, rand_req(), 1'b1);
                else req1_valid = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
